vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Single-port 8 KB video RAM with arbitration between the MC6847 VGA display's read port (RD/DA/DD) and the Z80 CPU's read/write port. It sits between the CPU bus decode and the display pipeline. It owns the VRAM storage and returns display bytes one clock after each read request. CPU accesses are queued into free slots, with a bounded wait.

## Interface
Parameters:
- STARVE_LIMIT, 32: maximum number of consecutive RD-busy cycles a pending CPU access waits before it is forced onto the RAM.

Ports:
- PIX_CLK  in  1  the only clock; the display pixel clock.
- RESET_N  in  1  asynchronous, active-low reset.
- RD  in  1  display read request; one RAM read per cycle in which it is high.
- DA  in  13  display read address.
- DD  out  8  display read data.
- CPU_REQ  in  1  CPU access request. A rising edge starts one access.
- CPU_WE  in  1  1 = write, 0 = read. Sampled on the CPU_REQ rising edge.
- CPU_A  in  13  CPU address. Sampled on the CPU_REQ rising edge.
- CPU_DO  in  8  CPU write data. Sampled on the CPU_REQ rising edge.
- CPU_DI  out  8  CPU read data. Valid while CPU_ACK=1, then held.
- CPU_ACK  out  1  single-cycle completion pulse.
- VID_DROP  out  1  one-cycle flag: a display read was lost to a CPU steal this cycle.

## Operation
- The block holds a 13-bit-address × 8-bit RAM with synchronous read and registered output.
- A CPU request is edge-qualified: `req_q` holds the previous CPU_REQ, and a request is recognised when CPU_REQ=1 and `req_q`=0. Edges seen outside S_IDLE are ignored.
- State machine:
  - **S_IDLE:** on a CPU_REQ rising edge, latch CPU_WE, CPU_A and CPU_DO, clear `starve_cnt`, and go to S_PEND.
  - **S_PEND:** grant when RD=0, or when `starve_cnt` = STARVE_LIMIT-1 and RD=1.
    - On grant, perform the RAM access with the latched operands and go to S_ACK.
    - Otherwise, increment `starve_cnt` (6 bits, saturating).
  - **S_ACK:** pulse CPU_ACK=1 and present CPU_DI (the read data; on a write, CPU_DI is unchanged). Return to S_IDLE.
- Ungranted cycles with RD=1 perform the display read: DD <= RAM[DA] at the next edge.
- Steal cycle (grant while RD=1):
  - The display read is suppressed and DD holds its previous value.
  - VID_DROP=1 in the following cycle, aligned with when DD would have updated.
- A CPU write and a display read are never performed to the RAM in the same cycle.
- Reads of the same address as a granted write in later cycles return the new data. There is no bypass within the same cycle, because they never share a cycle.

## Timing
- Reset values: DD=8'h00, CPU_DI=8'h00, CPU_ACK=0, VID_DROP=0, state S_IDLE, `starve_cnt`=0, `req_q`=0. RAM contents are not reset.
- Display latency: RD high with DA at edge N gives DD valid after edge N+1.
- CPU best case: rising edge seen at edge N goes to S_PEND; grant at edge N+1; CPU_ACK high after edge N+2 for one cycle.
- CPU worst case with RD held high: grant at the STARVE_LIMIT-th S_PEND cycle, then ACK one cycle later.
- RESET_N asserted mid-access abandons the pending operation:
  - no ACK is issued;
  - a write is not performed unless its grant edge already occurred.
- CPU_REQ must fall before a new access can be recognised. A level held through ACK does not retrigger.

## Configuration
- VRAM_SNOW_EN:
  - **Defined:** authentic VZ200 "snow" behaviour. In S_PEND, the grant happens on the first cycle regardless of RD. When the grant coincides with RD=1, DD is loaded with the CPU-accessed byte instead of RAM[DA] (CPU_DO for a write, RAM[latched addr] for a read), and VID_DROP pulses. STARVE_LIMIT is unused.
  - **Undefined:** display priority with the starvation limit, as described under Operation.

## Structure
- Package `vram_pkg`:
  - VRAM_AW=13, VRAM_DW=8;
  - the state enum (S_IDLE, S_PEND, S_ACK);
  - the `starve_cnt` width constant.
- Sub-module `vram_8k_sp`: a single-port synchronous RAM (we, addr, wdata, rdata), inferable as block RAM. The arbiter drives its single address/we mux.

## Test plan
- Reset, then preload by CPU writes of 8'hA5 to 13'h0010. Then RD=1, DA=13'h0010 → DD=8'hA5 one cycle later; VID_DROP stays 0.
- RD=0 continuously; CPU write 8'h3C to 13'h1FFF → CPU_ACK two cycles after the CPU_REQ edge. A CPU read of 13'h1FFF then returns CPU_DI=8'h3C.
- RD=1 continuously, STARVE_LIMIT=32, CPU read request → CPU_ACK exactly 33 cycles after the edge. VID_DROP pulses once, and DD holds its prior value in that cycle.
- With VRAM_SNOW_EN and RD=1, CPU write 8'h77 to 13'h0100 while DA=13'h0200 → DD=8'h77 for one cycle, VID_DROP=1, and RAM[13'h0100]=8'h77.
- RESET_N pulsed low while in S_PEND (RD=1) → no CPU_ACK, state S_IDLE, and the target byte is unchanged on readback.
- CPU_REQ held high across ACK → exactly one ACK. Dropping and re-raising CPU_REQ → a second ACK.

Source files
------------

// File: rtl/vram_pkg.sv
// vram_pkg: shared constants and types for the VRAM arbiter slice.
//   VRAM_AW / VRAM_DW : VRAM address and data widths (8 KB x 8).
//   STARVE_W          : width of the CPU starvation counter.
//   state_e           : arbiter state encoding.
package vram_pkg;

    localparam int unsigned VRAM_AW  = 13;
    localparam int unsigned VRAM_DW  = 8;
    localparam int unsigned STARVE_W = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_ACK
    } state_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: display read port plus Z80 CPU access port of the VRAM.
//   RD/DA/DD                      : display read request, address, data.
//   CPU_REQ/CPU_WE/CPU_A/CPU_DO   : CPU request (edge), write enable, address, write data.
//   CPU_DI/CPU_ACK                : CPU read data and completion pulse.
//   VID_DROP                      : display read lost to a CPU steal.
// Modports: master = display/CPU side, slave = arbiter.
interface vram_arbiter_if
    import vram_pkg::*;
();

    logic               RD;
    logic [VRAM_AW-1:0] DA;
    logic [VRAM_DW-1:0] DD;
    logic               CPU_REQ;
    logic               CPU_WE;
    logic [VRAM_AW-1:0] CPU_A;
    logic [VRAM_DW-1:0] CPU_DO;
    logic [VRAM_DW-1:0] CPU_DI;
    logic               CPU_ACK;
    logic               VID_DROP;

    modport master (
        output RD, DA, CPU_REQ, CPU_WE, CPU_A, CPU_DO,
        input  DD, CPU_DI, CPU_ACK, VID_DROP
    );

    modport slave (
        input  RD, DA, CPU_REQ, CPU_WE, CPU_A, CPU_DO,
        output DD, CPU_DI, CPU_ACK, VID_DROP
    );

endinterface

// File: rtl/vram_8k_sp.sv
// vram_8k_sp: single-port synchronous 8 KB RAM, inferable as block RAM.
//   clk   : clock
//   we    : write enable (no read is performed in a write cycle)
//   addr  : address
//   wdata : write data
//   rdata : registered read data of the last read cycle
module vram_8k_sp
    import vram_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [VRAM_AW-1:0] addr,
    input  logic [VRAM_DW-1:0] wdata,
    output logic [VRAM_DW-1:0] rdata
);

    logic [VRAM_DW-1:0] mem_q [0:(1 << VRAM_AW) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end else begin
            rdata <= mem_q[addr];
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: 8 KB VRAM shared between the MC6847 display read port and
// the Z80 CPU. Display reads take every free cycle; a CPU access waits for
// a cycle with RD=0, or is forced after STARVE_LIMIT busy cycles.
//   PIX_CLK : pixel clock (only clock)
//   RESET_N : asynchronous active-low reset
//   bus     : vram_arbiter_if.slave (display + CPU ports)
// Optional macro VRAM_SNOW_EN: grant the CPU immediately and show the CPU
// byte on DD when it collides with a display read ("snow").
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 32
)
(
    input  logic          PIX_CLK,
    input  logic          RESET_N,
    vram_arbiter_if.slave bus
);

    state_e              state_q, state_d;
    logic                req_q, req_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                we_q, we_d;
    logic [VRAM_AW-1:0]  addr_q, addr_d;
    logic [VRAM_DW-1:0]  wdata_q, wdata_d;
    logic                disp_rd_q, disp_rd_d;
    logic                steal_q, steal_d;
    logic [VRAM_DW-1:0]  dd_q, dd_d;
    logic [VRAM_DW-1:0]  cpu_di_q, cpu_di_d;
    logic                ack_q, ack_d;
    logic                vid_drop_q, vid_drop_d;
`ifdef VRAM_SNOW_EN
    logic                steal_we_q, steal_we_d;
`endif

    logic                grant;
    logic                req_edge;
    logic                ram_we;
    logic [VRAM_AW-1:0]  ram_addr;
    logic [VRAM_DW-1:0]  ram_rdata;

    vram_8k_sp u_ram (
        .clk   (PIX_CLK),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign req_edge = bus.CPU_REQ && !req_q;

    always_comb begin
        state_d      = state_q;
        req_d        = bus.CPU_REQ;
        starve_cnt_d = starve_cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        grant        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_edge) begin
                    we_d         = bus.CPU_WE;
                    addr_d       = bus.CPU_A;
                    wdata_d      = bus.CPU_DO;
                    starve_cnt_d = '0;
                    state_d      = S_PEND;
                end
            end
            S_PEND: begin
`ifdef VRAM_SNOW_EN
                grant = 1'b1;
`else
                grant = !bus.RD || (starve_cnt_q == STARVE_W'(STARVE_LIMIT - 1));
`endif
                if (grant) begin
                    state_d = S_ACK;
                end else if (starve_cnt_q != '1) begin
                    starve_cnt_d = starve_cnt_q + 1'b1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // One RAM port: a granted CPU access owns it, otherwise the display.
        ram_we   = grant && we_q;
        ram_addr = grant ? addr_q : bus.DA;

        // RAM output lands one edge after the access, so DD/VID_DROP/CPU_DI
        // are loaded from flags recorded at the access edge.
        disp_rd_d = bus.RD && !grant;
        steal_d   = bus.RD && grant;
`ifdef VRAM_SNOW_EN
        steal_we_d = we_q;
`endif

        dd_d = dd_q;
        if (disp_rd_q) begin
            dd_d = ram_rdata;
        end
`ifdef VRAM_SNOW_EN
        else if (steal_q) begin
            dd_d = steal_we_q ? wdata_q : ram_rdata;
        end
`endif
        vid_drop_d = steal_q;

        ack_d    = (state_q == S_ACK);
        cpu_di_d = cpu_di_q;
        if ((state_q == S_ACK) && !we_q) begin
            cpu_di_d = ram_rdata;
        end
    end

    always_ff @(posedge PIX_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            req_q        <= 1'b0;
            starve_cnt_q <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            disp_rd_q    <= 1'b0;
            steal_q      <= 1'b0;
            dd_q         <= '0;
            cpu_di_q     <= '0;
            ack_q        <= 1'b0;
            vid_drop_q   <= 1'b0;
`ifdef VRAM_SNOW_EN
            steal_we_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            starve_cnt_q <= starve_cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            disp_rd_q    <= disp_rd_d;
            steal_q      <= steal_d;
            dd_q         <= dd_d;
            cpu_di_q     <= cpu_di_d;
            ack_q        <= ack_d;
            vid_drop_q   <= vid_drop_d;
`ifdef VRAM_SNOW_EN
            steal_we_q   <= steal_we_d;
`endif
        end
    end

    assign bus.DD       = dd_q;
    assign bus.CPU_DI   = cpu_di_q;
    assign bus.CPU_ACK  = ack_q;
    assign bus.VID_DROP = vid_drop_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized and directed bench for vram_arbiter against a
// per-edge transaction model (VRAM array + pending CPU operation).
module tb_vram_arbiter;
    import vram_pkg::*;

    localparam int unsigned LIMIT = 32;

    logic pix_clk = 1'b0;
    logic rst_n;

    vram_arbiter_if bus ();

    vram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .PIX_CLK (pix_clk),
        .RESET_N (rst_n),
        .bus     (bus.slave)
    );

    always #5 pix_clk = ~pix_clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [0:8191];
    bit          m_req_prev, m_pend, m_we;
    int          m_wait;
    logic [12:0] m_a;
    logic [7:0]  m_do;
    bit          m_ack_next, m_ack_rd, m_dd_next, m_drop_next;
    logic [7:0]  m_ack_val, m_dd_val;
    logic [7:0]  e_dd, e_di;
    bit          e_ack, e_drop;
    int          acks, drops;

    function automatic void model_reset();
        m_req_prev = 0; m_pend = 0; m_we = 0; m_wait = 0;
        m_ack_next = 0; m_ack_rd = 0; m_dd_next = 0; m_drop_next = 0;
        e_dd = 8'h00; e_di = 8'h00; e_ack = 0; e_drop = 0;
    endfunction

    // Advance the model by one clock edge using the inputs now on the bus.
    function automatic void model_edge();
        bit idle_now;
        bit grant;
        idle_now = !m_pend && !m_ack_next;
        grant    = 0;
        // work started at the previous edge becomes visible now
        e_ack  = m_ack_next;
        if (m_ack_next && m_ack_rd) e_di = m_ack_val;
        e_drop = m_drop_next;
        if (m_dd_next) e_dd = m_dd_val;
        m_ack_next = 0; m_dd_next = 0; m_drop_next = 0;
        if (m_pend) begin
`ifdef VRAM_SNOW_EN
            grant = 1;
`else
            grant = !bus.RD || (m_wait == int'(LIMIT) - 1);
`endif
            if (grant) begin
                m_pend     = 0;
                m_ack_next = 1;
                m_ack_rd   = !m_we;
                m_ack_val  = ref_mem[m_a];
                if (bus.RD) begin
                    m_drop_next = 1;
`ifdef VRAM_SNOW_EN
                    m_dd_next = 1;
                    m_dd_val  = m_we ? m_do : ref_mem[m_a];
`endif
                end
                if (m_we) ref_mem[m_a] = m_do;
            end else begin
                m_wait++;
            end
        end
        if (bus.RD && !grant) begin
            m_dd_next = 1;
            m_dd_val  = ref_mem[bus.DA];
        end
        if (idle_now && bus.CPU_REQ && !m_req_prev) begin
            m_pend = 1; m_wait = 0;
            m_we = bus.CPU_WE; m_a = bus.CPU_A; m_do = bus.CPU_DO;
        end
        m_req_prev = bus.CPU_REQ;
    endfunction

    logic [7:0] prev_dd;

    task automatic step();
        model_edge();
        prev_dd = bus.DD;
        @(posedge pix_clk);
        #1;
        check("DD", bus.DD, e_dd);
        check("CPU_ACK", bus.CPU_ACK, e_ack);
        check("VID_DROP", bus.VID_DROP, e_drop);
        check("CPU_DI", bus.CPU_DI, e_di);
        if (bus.CPU_ACK) acks++;
        if (bus.VID_DROP) drops++;
    endtask

    // One CPU access; lat = edges from the recognising edge to the visible ACK.
    task automatic cpu_op(input bit we, input logic [12:0] a, input logic [7:0] d,
                          input int hold, output int lat, output logic [7:0] di,
                          output logic [7:0] ack_dd, output logic [7:0] ack_prev_dd,
                          output bit ack_drop);
        bus.CPU_WE = we; bus.CPU_A = a; bus.CPU_DO = d; bus.CPU_REQ = 1'b1;
        lat = -1; di = 8'h00; ack_dd = 8'h00; ack_prev_dd = 8'h00; ack_drop = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (bus.CPU_ACK) begin
                lat = i; di = bus.CPU_DI; ack_dd = bus.DD;
                ack_prev_dd = prev_dd; ack_drop = bus.VID_DROP;
                break;
            end
        end
        check("ACK_within_budget", 32'(lat >= 0), 1);
        for (int i = 0; i < hold; i++) step();
        bus.CPU_REQ = 1'b0;
        step();
    endtask

    int          lat, a0, d0;
    logic [7:0]  di, add, apd, old_val;
    bit          adrop;
    logic [12:0] pre_list [$];

    initial begin
        rst_n = 1'b0;
        bus.RD = 1'b0; bus.DA = '0; bus.CPU_REQ = 1'b0;
        bus.CPU_WE = 1'b0; bus.CPU_A = '0; bus.CPU_DO = '0;
        acks = 0; drops = 0;
        model_reset();
        repeat (3) @(posedge pix_clk);
        #1;
        check("rst_DD", bus.DD, 8'h00);
        check("rst_CPU_DI", bus.CPU_DI, 8'h00);
        check("rst_CPU_ACK", bus.CPU_ACK, 0);
        check("rst_VID_DROP", bus.VID_DROP, 0);
        rst_n = 1'b1;

        // preload every address the bench will ever read
        for (int i = 0; i < 32; i++) pre_list.push_back(13'(i));
        pre_list.push_back(13'h0100);
        pre_list.push_back(13'h0200);
        foreach (pre_list[k]) begin
            cpu_op(1'b1, pre_list[k], 8'($urandom), 0, lat, di, add, apd, adrop);
        end
        cpu_op(1'b1, 13'h0010, 8'hA5, 0, lat, di, add, apd, adrop);
        check("lat_best_write", lat, 2);
        cpu_op(1'b1, 13'h1FFF, 8'h3C, 0, lat, di, add, apd, adrop);
        check("lat_write_1FFF", lat, 2);

        // display read of preloaded byte
        a0 = drops;
        bus.RD = 1'b1; bus.DA = 13'h0010;
        step(); step();
        check("disp_DD_A5", bus.DD, 8'hA5);
        bus.RD = 1'b0;
        step(); step();
        check("disp_no_drop", drops - a0, 0);

        cpu_op(1'b0, 13'h1FFF, 8'h00, 0, lat, di, add, apd, adrop);
        check("lat_read_1FFF", lat, 2);
        check("read_1FFF", di, 8'h3C);

        // CPU read under continuous display reads
        bus.RD = 1'b1; bus.DA = 13'h0007;
        step(); step();
        a0 = drops;
        cpu_op(1'b0, 13'h0005, 8'h00, 0, lat, di, add, apd, adrop);
`ifdef VRAM_SNOW_EN
        check("lat_rd_busy", lat, 2);
`else
        check("lat_starve", lat, LIMIT + 1);
        check("starve_dd_hold", add, apd);
`endif
        check("starve_drop_at_ack", adrop, 1);
        check("starve_read_val", di, ref_mem[5]);
        check("starve_drop_once", drops - a0, 1);

`ifdef VRAM_SNOW_EN
        bus.RD = 1'b1; bus.DA = 13'h0200;
        step(); step();
        cpu_op(1'b1, 13'h0100, 8'h77, 0, lat, di, add, apd, adrop);
        check("snow_DD", add, 8'h77);
        check("snow_drop", adrop, 1);
        bus.RD = 1'b0;
        cpu_op(1'b0, 13'h0100, 8'h00, 0, lat, di, add, apd, adrop);
        check("snow_ram", di, 8'h77);
`endif

        // reset while a write is pending behind display reads
        bus.RD = 1'b1; bus.DA = 13'h0009;
        old_val = ref_mem[3];
        bus.CPU_WE = 1'b1; bus.CPU_A = 13'h0003; bus.CPU_DO = ~old_val; bus.CPU_REQ = 1'b1;
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        check("rst_mid_ack", bus.CPU_ACK, 0);
        check("rst_mid_DD", bus.DD, 8'h00);
        bus.CPU_REQ = 1'b0;
        @(posedge pix_clk); #1;
        @(posedge pix_clk); #1;
        model_reset();
        rst_n = 1'b1;
        bus.RD = 1'b0;
        a0 = acks;
        repeat (40) step();
        check("rst_no_ack", acks - a0, 0);
        cpu_op(1'b0, 13'h0003, 8'h00, 0, lat, di, add, apd, adrop);
        check("rst_idle_lat", lat, 2);
        check("rst_readback_model", di, ref_mem[3]);
`ifndef VRAM_SNOW_EN
        check("rst_readback_old", di, old_val);
`endif

        // level-held request gives one ACK; fall + rise gives another
        a0 = acks;
        cpu_op(1'b1, 13'h0004, 8'h5A, 6, lat, di, add, apd, adrop);
        check("held_one_ack", acks - a0, 1);
        cpu_op(1'b0, 13'h0004, 8'h00, 0, lat, di, add, apd, adrop);
        check("held_second_ack", acks - a0, 2);
        check("held_read_val", di, 8'h5A);

        // randomized traffic; operands change every cycle to exercise latching
        for (int c = 0; c < 600; c++) begin
            bus.RD = ($urandom_range(0, 3) != 0);
            bus.DA = 13'($urandom_range(0, 31));
            bus.CPU_WE = 1'($urandom);
            bus.CPU_A  = 13'($urandom_range(0, 31));
            bus.CPU_DO = 8'($urandom);
            if (!bus.CPU_REQ) begin
                if ($urandom_range(0, 3) == 0) bus.CPU_REQ = 1'b1;
            end else if ($urandom_range(0, 5) == 0) begin
                bus.CPU_REQ = 1'b0;
            end
            step();
        end
        bus.CPU_REQ = 1'b0; bus.RD = 1'b0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
